hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It decides each cycle whether the ID stage may advance, must insert a bubble into EX, or must squash the instruction in IF/ID, and it owns the busy counter of the multi-cycle multiply/divide unit. It sits beside the ID stage: its `id_flush` output drives ID's `ID_FLUSH`, and its write enables gate the PC and IF/ID registers.

## Interface
- `MD_LAT`, default 32: multiply/divide occupancy in cycles, from issue until HI/LO is valid. Legal range 1..255.
- `DELAY_SLOT`, default 1: 1 means the instruction after a taken branch or jump executes (no IF squash); 0 means it is squashed.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_rs`, `id_rt` in 5 each: source register fields of the instruction in ID.
- `id_use_rs`, `id_use_rt` in 1 each: the ID instruction actually reads rs / rt.
- `id_uncertain` in 1: the ID instruction is a branch or jr/jalr (ID's `o_uncertainJump`). It resolves in ID, so its operands must be forwardable from MEM/WB.
- `id_redirect` in 1: the ID instruction changes the PC this cycle (taken branch or any jump).
- `id_md` in 1: the ID instruction is mult/div.
- `id_hilo` in 1: the ID instruction is mfhi/mflo/mthi/mtlo.
- `ex_regWrite`, `ex_memRead` in 1 each; `ex_rw` in 5: destination info of the instruction in EX.
- `mem_memRead` in 1; `mem_rw` in 5: destination info of the instruction in MEM.
- `pc_we` out 1: PC register write enable.
- `ifid_we` out 1: IF/ID register write enable.
- `id_flush` out 1: load a bubble into ID/EX.
- `if_flush` out 1: clear IF/ID (squash the fetched instruction).
- `md_start` out 1: one-cycle start pulse to the mult/div unit.
- `md_busy` out 1: the mult/div unit is occupied.
- `stall_cnt` out 32: performance counter of stalled cycles.
- `stall_why` out 2: registered stall cause. 0 = RUN, 1 = DATA, 2 = MD.

## Operation
- **Register match.** `m(r) = (r != 0) && ((r == id_rs && id_use_rs) || (r == id_rt && id_use_rt))`.
- **Hazard terms:**
  - `h_lu = ex_memRead && m(ex_rw)` (load-use).
  - `h_bex = id_uncertain && ex_regWrite && m(ex_rw)` (branch operand still in EX).
  - `h_bmem = id_uncertain && mem_memRead && m(mem_rw)` (branch operand is load data still in MEM).
  - `h_md = (id_md || id_hilo) && md_busy`.
- **Stall.** `stall = h_lu | h_bex | h_bmem | h_md`.
- **Outputs (combinational):**
  - `pc_we = ifid_we = !stall`.
  - `id_flush = stall`.
  - `if_flush = id_redirect && !stall && !DELAY_SLOT`.
  - `md_start = id_md && !stall`.
- **Mult/div counter.** `md_cnt` is 8 bits and `md_busy = (md_cnt != 0)`. Next value of `md_cnt`:
  - `MD_LAT` if `md_start`;
  - otherwise `md_cnt - 1` if nonzero;
  - otherwise 0.
- **Stall-cause FSM.** Next `stall_why`:
  - MD (2) if `h_md`;
  - otherwise DATA (1) if any of `h_lu`, `h_bex`, `h_bmem`;
  - otherwise RUN (0).
  - MD has priority when both causes are present.
- **Performance counter.** `stall_cnt` increments on every cycle with `stall = 1` and wraps at 2^32.

## Timing
- **Reset.** While `rst` is high, regardless of the clock: `md_cnt = 0`, `stall_why = 0`, `stall_cnt = 0`. With all inputs at 0 the outputs are then `pc_we = 1`, `ifid_we = 1`, `id_flush = 0`, `if_flush = 0`, `md_start = 0`, `md_busy = 0`.
  - Reset asserted mid-divide clears `md_busy` immediately.
- **Latency.** Stall outputs have zero latency: they respond in the same cycle as the inputs. `md_busy` rises on the edge after `md_start`.
- **Load-use.** Causes exactly one stall cycle. Next cycle the load is in MEM, so `h_lu` clears and MEM/WB forwarding covers the operand.
- **Branch after ALU producer.** Causes 1 stall cycle.
- **Branch after load.** Causes 2 stall cycles: `h_bex`, then `h_bmem`.
- **Mult/div occupancy.**
  - `md_busy` stays high for exactly `MD_LAT` cycles after the issue edge.
  - A dependent mult/div/HI-LO instruction stalls `MD_LAT` cycles and proceeds in the first cycle with `md_cnt = 0`.
  - A back-to-back issue in that cycle reloads `md_cnt` to `MD_LAT`.
- **Simultaneous events.**
  - A stalled redirect does not squash: `if_flush = 0`. The redirect reappears after the stall releases.
  - A stalled `id_md` does not pulse `md_start`.
  - Register 0 never creates a hazard.

## Test plan
- **Load-use:** `ex_memRead = 1`, `ex_rw = 5`, `id_rs = 5`, `id_use_rs = 1` for one cycle, then the load advances. Required: 1 cycle with `pc_we = 0` and `id_flush = 1`; `stall_cnt` goes 0→1; `stall_why = 1` on the following cycle.
- **Branch after lw:** `id_uncertain = 1`, `id_rt = 8`, `id_use_rt = 1`. Cycle 1: EX holds lw to r8. Cycle 2: MEM holds lw to r8. Required: 2 stall cycles, then release; with `DELAY_SLOT = 0` and `id_redirect = 1`, `if_flush = 1` only in the release cycle.
- **Mult/div chain** (`MD_LAT = 4`): `id_md = 1` with no hazard. Required: `md_start` pulses once and `md_busy` is high for 4 cycles. A following `id_hilo = 1` stalls 4 cycles and `stall_why = 2`.
- **Register zero:** `ex_memRead = 1`, `ex_rw = 0`, `id_rs = 0`. Required: no stall.
- **Reset mid-divide:** assert `rst` asynchronously 2 cycles after `md_start`. Required: `md_busy = 0`, `stall_cnt = 0`, `stall_why = 0` immediately, without waiting for a clock edge.
- **Counter wrap:** force `stall_cnt = 0xFFFFFFFF`, then one stall cycle. Required: `stall_cnt = 0`.

Source files
------------

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline sequencing controller for the 5-stage core. Each cycle it decides
// whether the ID stage advances, inserts a bubble into EX, or squashes the
// fetched instruction. It also owns the busy counter of the multi-cycle
// multiply/divide unit.
//
// Parameters
//   MD_LAT      mult/div occupancy in cycles (1..255)
//   DELAY_SLOT  1: instruction after a redirect executes, 0: it is squashed
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   id_rs, id_rt             source register fields of the ID instruction
//   id_use_rs, id_use_rt     ID instruction really reads rs / rt
//   id_uncertain             ID instruction is a branch or jr/jalr
//   id_redirect              ID instruction changes the PC this cycle
//   id_md, id_hilo           ID instruction is mult/div, or a HI/LO access
//   ex_regWrite, ex_memRead, ex_rw   destination info of the EX instruction
//   mem_memRead, mem_rw      destination info of the MEM instruction
//   pc_we, ifid_we           PC and IF/ID write enables
//   id_flush                 load a bubble into ID/EX
//   if_flush                 clear IF/ID
//   md_start                 one-cycle start pulse to the mult/div unit
//   md_busy                  mult/div unit is occupied
//   stall_cnt                count of stalled cycles (wraps)
//   stall_why                registered stall cause: 0 RUN, 1 DATA, 2 MD
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned MD_LAT     = 32,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_uncertain,
  input  logic        id_redirect,
  input  logic        id_md,
  input  logic        id_hilo,
  input  logic        ex_regWrite,
  input  logic        ex_memRead,
  input  logic [4:0]  ex_rw,
  input  logic        mem_memRead,
  input  logic [4:0]  mem_rw,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        id_flush,
  output logic        if_flush,
  output logic        md_start,
  output logic        md_busy,
  output logic [31:0] stall_cnt,
  output logic [1:0]  stall_why
);

  typedef enum logic [1:0] {
    WHY_RUN  = 2'd0,
    WHY_DATA = 2'd1,
    WHY_MD   = 2'd2
  } why_e;

  localparam logic [7:0] MD_LAT_C = 8'(MD_LAT);

  // A destination register conflicts with ID only if it is nonzero and ID
  // really reads it; r0 is hardwired and never carries a dependency.
  function automatic logic reg_match(input logic [4:0] r,
                                     input logic [4:0] rs, input logic use_rs,
                                     input logic [4:0] rt, input logic use_rt);
    return (r != 5'd0) && (((r == rs) && use_rs) || ((r == rt) && use_rt));
  endfunction

  logic [7:0]  md_cnt_q, md_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  why_e        why_q, why_d;

  logic m_ex, m_mem;
  logic h_lu, h_bex, h_bmem, h_md, h_data, stall;

  // Hazard detection and the zero-latency pipeline controls.
  always_comb begin
    m_ex    = reg_match(ex_rw, id_rs, id_use_rs, id_rt, id_use_rt);
    m_mem   = reg_match(mem_rw, id_rs, id_use_rs, id_rt, id_use_rt);
    md_busy = (md_cnt_q != 8'd0);
    h_lu    = ex_memRead && m_ex;
    // Branches resolve in ID, so an operand still in EX cannot be forwarded,
    // and load data still in MEM is not available until WB.
    h_bex   = id_uncertain && ex_regWrite && m_ex;
    h_bmem  = id_uncertain && mem_memRead && m_mem;
    h_md    = (id_md || id_hilo) && md_busy;
    h_data  = h_lu || h_bex || h_bmem;
    stall   = h_data || h_md;

    pc_we    = !stall;
    ifid_we  = !stall;
    id_flush = stall;
    // A stalled redirect is held in ID and takes effect when it releases.
    if_flush = id_redirect && !stall && !DELAY_SLOT;
    md_start = id_md && !stall;
  end

  // Mult/div occupancy counter and stall performance counter.
  always_comb begin
    md_cnt_d = 8'd0;
    if (md_start) begin
      md_cnt_d = MD_LAT_C;
    end else if (md_cnt_q != 8'd0) begin
      md_cnt_d = md_cnt_q - 8'd1;
    end
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
  end

  // Stall-cause FSM: next-state logic. MD wins over DATA when both are present.
  always_comb begin
    why_d = WHY_RUN;
    if (h_md) begin
      why_d = WHY_MD;
    end else if (h_data) begin
      why_d = WHY_DATA;
    end
  end

  // Stall-cause FSM: output logic.
  always_comb begin
    stall_why = why_q;
    stall_cnt = stall_cnt_q;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_cnt_q    <= 8'd0;
      stall_cnt_q <= 32'd0;
      why_q       <= WHY_RUN;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      why_q       <= why_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int unsigned MD_LAT = 4;
  localparam bit          DS     = 1'b0;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]  id_rs = '0, id_rt = '0, ex_rw = '0, mem_rw = '0;
  logic        id_use_rs = 0, id_use_rt = 0, id_uncertain = 0, id_redirect = 0;
  logic        id_md = 0, id_hilo = 0, ex_regWrite = 0, ex_memRead = 0, mem_memRead = 0;
  logic        pc_we, ifid_we, id_flush, if_flush, md_start, md_busy;
  logic [31:0] stall_cnt;
  logic [1:0]  stall_why;

  hazard_ctrl #(.MD_LAT(MD_LAT), .DELAY_SLOT(DS)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_uncertain(id_uncertain), .id_redirect(id_redirect),
    .id_md(id_md), .id_hilo(id_hilo),
    .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_rw(ex_rw),
    .mem_memRead(mem_memRead), .mem_rw(mem_rw),
    .pc_we(pc_we), .ifid_we(ifid_we), .id_flush(id_flush), .if_flush(if_flush),
    .md_start(md_start), .md_busy(md_busy), .stall_cnt(stall_cnt), .stall_why(stall_why)
  );

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs, use_rt, unc, redir, md, hilo, ex_rwe, ex_mr;
    logic [4:0] ex_rw;
    logic       mem_mr;
    logic [4:0] mem_rw;
  } stim_t;

  // {pc_we, ifid_we, id_flush, if_flush, md_start, md_busy, stall_why, stall_cnt}
  logic [39:0] exp_q[$];
  string       name_q[$];
  int          total = 0;
  int          bad   = 0;
  event        drv_ev;

  // ---------------------------------------------------------------- reference model
  // Mult/div occupancy is tracked as "issue cycle number": the unit is busy
  // in the MD_LAT cycles following the issue cycle.
  int          cyc_n     = 0;
  bit          issued    = 0;
  int          issue_cyc = 0;
  logic [1:0]  m_why     = 2'd0;
  logic [31:0] m_cnt     = 32'd0;

  function automatic bit reads(input logic [4:0] r, input stim_t s);
    if (r == 5'd0) return 1'b0;
    return (s.use_rs && s.rs == r) || (s.use_rt && s.rt == r);
  endfunction

  task automatic model(input logic r, input stim_t s, input string nm);
    bit busy, lu, bex, bmem, mdh, data, st, start;
    if (r) begin
      issued = 0;
      m_why  = 2'd0;
      m_cnt  = 32'd0;
    end
    busy  = issued && ((cyc_n - issue_cyc) <= int'(MD_LAT));
    lu    = s.ex_mr && reads(s.ex_rw, s);
    bex   = s.unc && s.ex_rwe && reads(s.ex_rw, s);
    bmem  = s.unc && s.mem_mr && reads(s.mem_rw, s);
    mdh   = (s.md || s.hilo) && busy;
    data  = lu || bex || bmem;
    st    = data || mdh;
    start = s.md && !st;
    exp_q.push_back({!st, !st, st, s.redir && !st && !DS, start, busy, m_why, m_cnt});
    name_q.push_back(nm);
    if (!r) begin
      if (start) begin
        issued    = 1;
        issue_cyc = cyc_n;
      end
      m_why = mdh ? 2'd2 : (data ? 2'd1 : 2'd0);
      if (st) m_cnt = m_cnt + 32'd1;
    end
    cyc_n++;
  endtask

  // ---------------------------------------------------------------- driver
  task automatic apply(input logic r, input stim_t s);
    rst          = r;
    id_rs        = s.rs;
    id_rt        = s.rt;
    id_use_rs    = s.use_rs;
    id_use_rt    = s.use_rt;
    id_uncertain = s.unc;
    id_redirect  = s.redir;
    id_md        = s.md;
    id_hilo      = s.hilo;
    ex_regWrite  = s.ex_rwe;
    ex_memRead   = s.ex_mr;
    ex_rw        = s.ex_rw;
    mem_memRead  = s.mem_mr;
    mem_rw       = s.mem_rw;
  endtask

  // Inputs change on the falling edge, away from the active edge.
  task automatic cyc(input logic r, input stim_t s, input string nm);
    @(negedge clk);
    apply(r, s);
    model(r, s, nm);
    -> drv_ev;
  endtask

  // Preload the stall counter just below its wrap point, then run one cycle.
  task automatic wrap_cyc(input stim_t s, input string nm);
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    apply(1'b0, s);
    model(1'b0, s, nm);
    -> drv_ev;
  endtask

  function automatic stim_t rnd_stim();
    stim_t s;
    s.rs     = 5'($urandom_range(0, 3));
    s.rt     = 5'($urandom_range(0, 3));
    s.use_rs = 1'($urandom_range(0, 1));
    s.use_rt = 1'($urandom_range(0, 1));
    s.unc    = ($urandom_range(0, 3) == 0);
    s.redir  = ($urandom_range(0, 3) == 0);
    s.md     = ($urandom_range(0, 7) == 0);
    s.hilo   = ($urandom_range(0, 7) == 0);
    s.ex_rwe = 1'($urandom_range(0, 1));
    s.ex_mr  = ($urandom_range(0, 3) == 0);
    s.ex_rw  = 5'($urandom_range(0, 3));
    s.mem_mr = ($urandom_range(0, 3) == 0);
    s.mem_rw = 5'($urandom_range(0, 3));
    return s;
  endfunction

  // ---------------------------------------------------------------- monitor / scoreboard
  initial begin
    logic [39:0] got, want;
    string nm;
    forever begin
      @(drv_ev);
      #2;
      got = {pc_we, ifid_we, id_flush, if_flush, md_start, md_busy, stall_why, stall_cnt};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_underflow got=%h want=<none>", got);
      end else begin
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL %s t=%0t got pc/ifid/idf/iff/start/busy=%b why=%0d cnt=%h want %b why=%0d cnt=%h",
                   nm, $time, got[39:34], got[33:32], got[31:0], want[39:34], want[33:32], want[31:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    stim_t z, s;
    z = '0;

    cyc(1'b1, z, "reset0");
    cyc(1'b1, z, "reset1");
    cyc(1'b0, z, "idle");

    // Load-use: one stall, then the load sits in MEM and is forwarded.
    s = z; s.ex_mr = 1; s.ex_rwe = 1; s.ex_rw = 5'd5; s.rs = 5'd5; s.use_rs = 1;
    cyc(1'b0, s, "lu_stall");
    s.ex_mr = 0; s.ex_rwe = 0; s.ex_rw = 0; s.mem_mr = 1; s.mem_rw = 5'd5;
    cyc(1'b0, s, "lu_release");
    cyc(1'b0, z, "lu_after");

    // Branch after lw: two stalls, squash only in the release cycle.
    s = z; s.unc = 1; s.redir = 1; s.rt = 5'd8; s.use_rt = 1;
    s.ex_rwe = 1; s.ex_mr = 1; s.ex_rw = 5'd8;
    cyc(1'b0, s, "blw_ex");
    s.ex_rwe = 0; s.ex_mr = 0; s.ex_rw = 0; s.mem_mr = 1; s.mem_rw = 5'd8;
    cyc(1'b0, s, "blw_mem");
    s.mem_mr = 0; s.mem_rw = 0;
    cyc(1'b0, s, "blw_release");

    // Branch after ALU producer: one stall.
    s = z; s.unc = 1; s.rs = 5'd9; s.use_rs = 1; s.ex_rwe = 1; s.ex_rw = 5'd9;
    cyc(1'b0, s, "balu_stall");
    s.ex_rwe = 0; s.ex_rw = 0;
    cyc(1'b0, s, "balu_release");

    // Register zero never hazards.
    s = z; s.ex_mr = 1; s.ex_rwe = 1; s.ex_rw = 5'd0; s.rs = 5'd0; s.use_rs = 1;
    cyc(1'b0, s, "r0_no_stall");

    // Mult/div chain: issue, dependent HI/LO access, back-to-back md issue.
    s = z; s.md = 1;
    cyc(1'b0, s, "md_issue");
    s = z; s.hilo = 1;
    for (int i = 0; i < 5; i++) cyc(1'b0, s, "md_hilo");
    s = z; s.md = 1;
    for (int i = 0; i < 6; i++) cyc(1'b0, s, "md_b2b");
    s = z; s.md = 1; s.ex_mr = 1; s.ex_rw = 5'd3; s.rs = 5'd3; s.use_rs = 1;
    for (int i = 0; i < 3; i++) cyc(1'b0, s, "md_both_causes");
    for (int i = 0; i < 5; i++) cyc(1'b0, z, "md_drain");

    // Reset mid-divide: rst rises between clock edges.
    s = z; s.md = 1;
    cyc(1'b0, s, "rmd_issue");
    cyc(1'b0, z, "rmd_busy1");
    cyc(1'b0, z, "rmd_busy2");
    s = z; s.hilo = 1;
    cyc(1'b1, s, "rmd_async_reset");
    cyc(1'b0, s, "rmd_after");

    // Counter wrap.
    s = z; s.ex_mr = 1; s.ex_rw = 5'd7; s.rt = 5'd7; s.use_rt = 1;
    wrap_cyc(s, "wrap_stall");
    cyc(1'b0, z, "wrap_zero");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 63) == 0), rnd_stim(), "random");
    end
    cyc(1'b0, z, "final_idle");

    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
